// File: rtl/dct_transpose_buf.sv
// 8x8 transpose buffer between the row DCT and the column DCT: rows in, columns out.
// Define DCT_TRANSPOSE_PINGPONG_EN for two concurrent banks; otherwise one bank alternates FILL/DRAIN.
module dct_transpose_buf #(
  parameter int DW = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0][DW-1:0] in_row,
  input  logic               in_valid,
  input  logic               in_first,
  output logic               in_ready,
  output logic [7:0][DW-1:0] out_col,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready
);

  logic [2:0] wr_row;
  logic [2:0] rd_col;
  logic [2:0] row_idx;
  logic       acc;
  logic       beat;

  assign acc      = in_valid && in_ready;
  assign beat     = out_valid && out_ready;
  // A row flagged in_first always lands in row 0, abandoning any partial block
  assign row_idx  = in_first ? 3'd0 : wr_row;
  assign out_last = out_valid && (rd_col == 3'd7);

`ifdef DCT_TRANSPOSE_PINGPONG_EN

  logic [7:0][DW-1:0] mem [2][8];
  logic [1:0]         full;
  logic               wr_bank;
  logic               rd_bank;

  // The fill bank is only full when both banks are, so this is the "both full" stall
  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];

  always_ff @(posedge clk) begin
    if (acc) mem[wr_bank][row_idx] <= in_row;
  end

  always_comb begin
    for (int r = 0; r < 8; r++) out_col[r] = mem[rd_bank][r][rd_col];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row  <= 3'd0;
      rd_col  <= 3'd0;
    end else begin
      if (acc) begin
        wr_row <= row_idx + 3'd1;
        if (row_idx == 3'd7) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
        end
      end
      if (beat) begin
        rd_col <= rd_col + 3'd1;
        if (rd_col == 3'd7) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= !rd_bank;
        end
      end
    end
  end

`else

  typedef enum logic {FILL, DRAIN} state_t;

  state_t             state;
  logic [7:0][DW-1:0] mem [8];

  always_ff @(posedge clk) begin
    if (acc) mem[row_idx] <= in_row;
  end

  always_comb begin
    for (int r = 0; r < 8; r++) out_col[r] = mem[r][rd_col];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      wr_row    <= 3'd0;
      rd_col    <= 3'd0;
    end else begin
      case (state)
        FILL: begin
          if (acc) begin
            wr_row <= row_idx + 3'd1;
            if (row_idx == 3'd7) begin
              state     <= DRAIN;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (beat) begin
            rd_col <= rd_col + 3'd1;
            if (rd_col == 3'd7) begin
              state     <= FILL;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`endif

endmodule

// File: doc/dct_transpose_buf.md
DCT_TRANSPOSE_BUF -- requirements
Module: dct_transpose_buf

Interface
REQ-001 SHALL have parameter DW, default 18, giving the signed coefficient width (the row DCT output width).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 SHALL have port in_row, input, 8 x DW, the row vector y[0..7] from the row DCT.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning in_row is valid this cycle.
REQ-006 SHALL have port in_first, input, 1 bit, meaning this row is row 0 of a block; sampled only with in_valid.
REQ-007 SHALL have port in_ready, output, 1 bit, meaning the buffer accepts a row this cycle.
REQ-008 SHALL have port out_col, output, 8 x DW, the column vector for the column DCT.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning out_col is valid.
REQ-010 SHALL have port out_last, output, 1 bit, meaning out_col is column 7 of the block.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning downstream accepts out_col.

Function
REQ-012 SHALL accept a row when in_valid and in_ready are both high on a rising edge, and write it to row index wr_row of the fill bank.
REQ-013 SHALL increment wr_row (0..7) on each accepted row; row 7 accepted marks the bank FULL and wraps wr_row to 0.
REQ-014 SHALL restart the fill at row 0 when an accepted row has in_first=1 and wr_row!=0, discarding the partial block; the flagged row is stored as row 0.
REQ-015 SHALL drive out_valid high from the cycle after the row-7 acceptance until column 7 of that bank is accepted.
REQ-016 SHALL drive out_col[r] = bank[r][rd_col] for r=0..7, i.e. element r of column rd_col is row r's coefficient rd_col.
REQ-017 SHALL advance rd_col (0..7) on each out_valid and out_ready beat; out_last = out_valid and rd_col==7; the column-7 beat frees the bank and wraps rd_col to 0.
REQ-018 SHALL hold out_col, out_valid and out_last stable while out_valid=1 and out_ready=0.
REQ-019 SHALL pass coefficients bit-exact (no rounding or truncation); storage is 64 x DW bits per bank.
REQ-020 SHALL give a minimum latency of 1 cycle from the row-7 acceptance edge to out_valid=1 for column 0.
REQ-021 SHALL drain banks strictly in fill order.
REQ-022 SHALL ignore in_row and in_first while in_ready=0 and not store them.

Reset
REQ-023 SHALL on rst_n=0 immediately clear wr_row, rd_col, bank select and all bank-full flags.
REQ-024 SHALL hold out_valid=0, out_last=0 and in_ready=1 while rst_n=0 and after release.
REQ-025 SHALL NOT reset bank contents; out_col value is don't-care while out_valid=0.
REQ-026 SHALL lose any partially filled or partially drained block on reset mid-operation; the first row accepted after reset is row 0.

Configuration
REQ-027 SHALL provide macro DCT_TRANSPOSE_PINGPONG_EN.
REQ-028 SHALL, with DCT_TRANSPOSE_PINGPONG_EN defined, implement two banks that fill and drain concurrently; in_ready=0 only when both banks are FULL; a row write and a column read in the same cycle to different banks both complete.
REQ-029 SHALL, with DCT_TRANSPOSE_PINGPONG_EN undefined, implement one bank with states FILL (in_ready=1, out_valid=0) and DRAIN (in_ready=0, out_valid=1).
REQ-030 SHALL, in single-bank mode, move FILL->DRAIN on the row-7 acceptance, move DRAIN->FILL on the column-7 acceptance, and raise in_ready in the cycle after that acceptance.

Verification
REQ-031 SHALL cover: one block with row r = {8r+0..8r+7}, out_ready=1 -> columns {c, 8+c, ..., 56+c} for c=0..7, out_last only on c=7, out_valid 1 cycle after row 7.
REQ-032 SHALL cover: a block of values -131072 and +131071 (DW=18) -> output bit-exact, with no sign corruption.
REQ-033 SHALL cover: out_ready toggling 1/0 every cycle during drain -> out_col stable during stalls, 8 beats total, column order preserved.
REQ-034 SHALL cover: 3 rows accepted, then a row with in_first=1, then 7 more rows -> the output block contains only the last 8 rows.
REQ-035 SHALL cover: rst_n pulsed low after row 5 -> out_valid=0 and in_ready=1, and the next 8 rows form a correct block.
REQ-036 SHALL cover: back-to-back blocks with out_ready=1 -> the PINGPONG build sustains 1 row/cycle with in_ready high throughout; the single-bank build drops in_ready for exactly 8 cycles per block.
